nonce_range_scheduler: RTL

- Next-generation mining supervisor. It drives an external array of NUM_MINERS SHA-256d miners across a programmable nonce range [nonce_first, nonce_last].
- It scores every hash by leading-zero count and streams qualifying (nonce, hash) results through an internal result FIFO.
- It supports stop-on-first and exhaustive modes, abort, and progress counters.
- It sits between the AXI config-register block and the miner array.

---
 rtl/nonce_range_scheduler_if.sv | 43 ++++
 rtl/nonce_range_scheduler.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nonce_range_scheduler_if.sv
// rtl/nonce_range_scheduler_if.sv - miner array bus and result stream bundle
//
// Purpose: groups the miner-array handshake and the result stream of
// nonce_range_scheduler into one interface.
//   miner_reset  scheduler -> miners  one-cycle reset pulse to all miners
//   miner_start  scheduler -> miners  held high while miners run
//   miner_nonce  scheduler -> miners  nonce for miner i in slice i (32 bits each)
//   miner_done   miners -> scheduler  per-miner done level
//   miner_hash   miners -> scheduler  per-miner hash (256 bits each), valid while done
//   res_valid    scheduler -> sink    result FIFO non-empty
//   res_ready    sink -> scheduler    pop when res_valid & res_ready
//   res_nonce    scheduler -> sink    head-entry nonce
//   res_hash     scheduler -> sink    head-entry hash
//   res_zeros    scheduler -> sink    head-entry leading-zero count
// master = scheduler side, slave = miner array / result consumer side.
interface nonce_range_scheduler_if #(
  parameter int NUM_MINERS = 4
);
  logic                      miner_reset;
  logic                      miner_start;
  logic [32*NUM_MINERS-1:0]  miner_nonce;
  logic [NUM_MINERS-1:0]     miner_done;
  logic [256*NUM_MINERS-1:0] miner_hash;
  logic                      res_valid;
  logic                      res_ready;
  logic [31:0]               res_nonce;
  logic [255:0]              res_hash;
  logic [8:0]                res_zeros;

  modport master (
    output miner_reset, miner_start, miner_nonce,
    input  miner_done, miner_hash,
    output res_valid, res_nonce, res_hash, res_zeros,
    input  res_ready
  );

  modport slave (
    input  miner_reset, miner_start, miner_nonce,
    output miner_done, miner_hash,
    input  res_valid, res_nonce, res_hash, res_zeros,
    output res_ready
  );
endinterface

// File: rtl/nonce_range_scheduler.sv
// rtl/nonce_range_scheduler.sv - nonce range scheduler for a SHA-256d miner array
//
// Purpose: walks a nonce range [nonce_first, nonce_last] in batches of
// NUM_MINERS, launches the miner array per batch, scores each returned hash
// by leading-zero count and queues hits in a result FIFO.
// Ports:
//   clk, reset              clock, synchronous active-high reset
//   start                   rising-edge start (only in IDLE/DONE)
//   abort                   forces a busy run to DONE
//   exhaustive              0 = stop on first hit, 1 = scan whole range
//   nonce_first/nonce_last  inclusive nonce range, sampled at start
//   target_zeros            required leading zeros, sampled at start
//   bus                     miner array bus and result stream (master)
//   busy, done, found       run status
//   hashes_tried            nonces evaluated this run, saturating
//   res_count               result FIFO occupancy
//   res_overflow            sticky: stop-mode hit dropped on a full FIFO
module nonce_range_scheduler #(
  parameter int NUM_MINERS   = 4,
  parameter int RESULT_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic                          abort,
  input  logic                          exhaustive,
  input  logic [31:0]                   nonce_first,
  input  logic [31:0]                   nonce_last,
  input  logic [8:0]                    target_zeros,
  nonce_range_scheduler_if.master       bus,
  output logic                          busy,
  output logic                          done,
  output logic                          found,
  output logic [31:0]                   hashes_tried,
  output logic [$clog2(RESULT_DEPTH):0] res_count,
  output logic                          res_overflow
);

  localparam int IW = $clog2(NUM_MINERS + 1);
  localparam int AW = $clog2(RESULT_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_LAUNCH, S_WAIT, S_CAPTURE, S_SCAN, S_ADVANCE, S_DONE
  } state_t;

  state_t state_q, state_d;

  logic          start_d;
  logic          abort_rst_q;
  logic          ex_q;
  logic [31:0]   last_q;
  logic [8:0]    target_q;
  logic [32:0]   base_q;
  logic [255:0]  hash_q [NUM_MINERS];
  logic [IW-1:0] idx_q;

  logic          s1_valid;
  logic          s1_lane_ok;
  logic [31:0]   s1_nonce;
  logic [255:0]  s1_hash;
  logic [8:0]    s1_zeros;

  logic          found_q;
  logic [31:0]   hashes_q;
  logic          ovf_q;

  logic [31:0]   fifo_nonce [RESULT_DEPTH];
  logic [255:0]  fifo_hash  [RESULT_DEPTH];
  logic [8:0]    fifo_zeros [RESULT_DEPTH];
  logic [CW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] fifo_count;
  logic          fifo_full, fifo_empty;

  // Leading zeros from bit 255 downward; all-zero hash scores 256.
  function automatic logic [8:0] clz256(input logic [255:0] h);
    logic [8:0] n;
    logic       seen;
    n    = 9'd0;
    seen = 1'b0;
    for (int b = 255; b >= 0; b--) begin
      if (!seen) begin
        if (h[b]) seen = 1'b1;
        else      n = n + 9'd1;
      end
    end
    return n;
  endfunction

  logic                     start_pulse;
  logic                     is_busy;
  logic                     abort_now;
  logic [32:0]              lane_sum [NUM_MINERS];
  logic [NUM_MINERS-1:0]    lane_valid;
  logic [32*NUM_MINERS-1:0] nonce_bus;
  logic                     all_done;

  assign start_pulse = start & ~start_d;
  assign is_busy     = (state_q != S_IDLE) && (state_q != S_DONE);
  assign abort_now   = abort & is_busy;

  // Lane arithmetic is 33-bit so base+i past 0xFFFFFFFF never wraps into range.
  always_comb begin
    nonce_bus  = '0;
    lane_valid = '0;
    for (int i = 0; i < NUM_MINERS; i++) begin
      lane_sum[i]             = base_q + 33'(i);
      lane_valid[i]           = lane_sum[i] <= {1'b0, last_q};
      nonce_bus[i*32 +: 32]   = lane_sum[i][31:0];
    end
  end

  assign all_done        = &(bus.miner_done | ~lane_valid);
  assign bus.miner_nonce = is_busy ? nonce_bus : '0;

  // Stage 1 lane select and scoring.
  logic [255:0] sel_hash;
  logic [31:0]  sel_nonce;
  logic         sel_ok;
  logic [8:0]   sel_zeros;

  always_comb begin
    sel_hash  = '0;
    sel_nonce = '0;
    sel_ok    = 1'b0;
    for (int i = 0; i < NUM_MINERS; i++) begin
      if (idx_q == IW'(i)) begin
        sel_hash  = hash_q[i];
        sel_nonce = lane_sum[i][31:0];
        sel_ok    = lane_valid[i];
      end
    end
  end

  assign sel_zeros = clz256(sel_hash);

  // FIFO status and stage 2 decisions.
  logic pop, can_push, scan_live, s1_hit, stall, scan_step, stop_hit, push;
  logic last_issued;
  logic [32:0] next_base;

  assign fifo_count  = wr_ptr - rd_ptr;
  assign fifo_full   = fifo_count == CW'(RESULT_DEPTH);
  assign fifo_empty  = fifo_count == '0;
  assign pop         = ~fifo_empty & bus.res_ready;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign can_push    = ~fifo_full | pop;

  assign scan_live   = (state_q == S_SCAN) & ~abort;
  assign s1_hit      = s1_valid & s1_lane_ok & (s1_zeros >= target_q);
  assign stall       = scan_live & s1_hit & ex_q & ~can_push;
  assign scan_step   = scan_live & ~stall;
  assign stop_hit    = scan_step & s1_hit & ~ex_q;
  assign push        = scan_step & s1_hit & can_push;
  assign last_issued = idx_q == IW'(NUM_MINERS);
  assign next_base   = base_q + 33'(NUM_MINERS);

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // FSM next state and control outputs.
  always_comb begin
    state_d         = state_q;
    bus.miner_start = 1'b0;
    bus.miner_reset = abort_rst_q;
    busy            = is_busy;
    done            = state_q == S_DONE;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_pulse) state_d = (nonce_last < nonce_first) ? S_DONE : S_LAUNCH;
      end
      S_LAUNCH: begin
        bus.miner_reset = 1'b1;
        bus.miner_start = 1'b1;
        state_d         = S_WAIT;
      end
      S_WAIT: begin
        bus.miner_start = 1'b1;
        if (all_done) state_d = S_CAPTURE;
      end
      S_CAPTURE: state_d = S_SCAN;
      S_SCAN: begin
        if (stop_hit)                     state_d = S_DONE;
        else if (scan_step && last_issued) state_d = S_ADVANCE;
      end
      S_ADVANCE: state_d = (next_base > {1'b0, last_q}) ? S_DONE : S_LAUNCH;
      default:   state_d = S_IDLE;
    endcase
    if (abort_now) state_d = S_DONE;
  end

  // Datapath.
  always_ff @(posedge clk) begin
    if (reset) begin
      start_d     <= 1'b0;
      abort_rst_q <= 1'b0;
      ex_q        <= 1'b0;
      last_q      <= '0;
      target_q    <= '0;
      base_q      <= '0;
      idx_q       <= '0;
      s1_valid    <= 1'b0;
      s1_lane_ok  <= 1'b0;
      s1_nonce    <= '0;
      s1_hash     <= '0;
      s1_zeros    <= '0;
      found_q     <= 1'b0;
      hashes_q    <= '0;
      ovf_q       <= 1'b0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      for (int i = 0; i < NUM_MINERS; i++) hash_q[i] <= '0;
    end else begin
      start_d     <= start;
      abort_rst_q <= abort_now;

      if ((state_q == S_IDLE || state_q == S_DONE) && start_pulse) begin
        ex_q     <= exhaustive;
        last_q   <= nonce_last;
        target_q <= target_zeros;
        base_q   <= {1'b0, nonce_first};
        found_q  <= 1'b0;
        hashes_q <= '0;
        ovf_q    <= 1'b0;
      end

      // Hashes are taken on the WAIT->CAPTURE edge, while done is still
      // guaranteed high on every valid lane.
      if (state_q == S_WAIT && all_done && !abort) begin
        for (int i = 0; i < NUM_MINERS; i++) hash_q[i] <= bus.miner_hash[i*256 +: 256];
      end

      if (state_q == S_CAPTURE) begin
        idx_q    <= '0;
        s1_valid <= 1'b0;
      end

      if (scan_step) begin
        if (!last_issued) begin
          s1_valid   <= 1'b1;
          s1_lane_ok <= sel_ok;
          s1_nonce   <= sel_nonce;
          s1_hash    <= sel_hash;
          s1_zeros   <= sel_zeros;
          idx_q      <= idx_q + IW'(1);
        end else begin
          s1_valid <= 1'b0;
        end
        if (s1_valid && s1_lane_ok && hashes_q != '1) hashes_q <= hashes_q + 32'd1;
        if (s1_hit) found_q <= 1'b1;
        if (stop_hit && !can_push) ovf_q <= 1'b1;
      end

      if (state_q == S_ADVANCE && !abort) base_q <= next_base;

      if (push) wr_ptr <= wr_ptr + CW'(1);
      if (pop)  rd_ptr <= rd_ptr + CW'(1);
    end
  end

  // FIFO storage needs no reset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_nonce[wr_ptr[AW-1:0]] <= s1_nonce;
      fifo_hash[wr_ptr[AW-1:0]]  <= s1_hash;
      fifo_zeros[wr_ptr[AW-1:0]] <= s1_zeros;
    end
  end

  assign bus.res_valid = ~fifo_empty;
  assign bus.res_nonce = fifo_empty ? '0 : fifo_nonce[rd_ptr[AW-1:0]];
  assign bus.res_hash  = fifo_empty ? '0 : fifo_hash[rd_ptr[AW-1:0]];
  assign bus.res_zeros = fifo_empty ? '0 : fifo_zeros[rd_ptr[AW-1:0]];

  assign found        = found_q;
  assign hashes_tried = hashes_q;
  assign res_count    = fifo_count;
  assign res_overflow = ovf_q;

endmodule
